// File: rtl/byte_encode.sv
// byte_encode: registered ByteEncode_d for the Kyber-768-90s datapath.
// Packs 8*BYTE_LEN coefficients of D bits each into BYTE_LEN*D bytes,
// LSB-first, no padding. Encoding is combinational; only B and done are
// registered, giving one cycle of latency per start.
//
// Optional feature macro: BYTE_ENCODE_MODQ_EN
//   defined   -> for D=12 each signed 16-bit coefficient is fully reduced
//                mod 3329 before packing (negative inputs map upward).
//   undefined -> for D=12 the low 12 bits are packed unchanged; the caller
//                keeps coefficients in [0,3328].
// D<12 always packs the low D bits of the two's-complement value.
`timescale 1ns/1ps

module byte_encode #(
    parameter int D        = 12,
    parameter int BYTE_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] F [8*BYTE_LEN-1:0],
    output logic [7:0]         B [BYTE_LEN*D-1:0],
    output logic               done
);

    localparam int unsigned NCOEF = 8 * BYTE_LEN;
    localparam int unsigned NBYTE = BYTE_LEN * D;
    localparam int unsigned NBITS = NCOEF * D;

    // Elaboration-time guard on the legal parameter space.
    if (D < 1 || D > 12) begin : g_bad_d
        $error("byte_encode: D must be in 1..12");
    end
    if (BYTE_LEN != 32) begin : g_bad_len
        $error("byte_encode: BYTE_LEN is fixed at 32");
    end

    // Residue of a signed 16-bit value mod 3329 in [0,3328].
    // An offset of 10*q makes every input non-negative (522..66057); a
    // Barrett estimate with 5039/2^24 ~ 1/3329 undershoots the quotient by
    // at most one, so a single conditional subtraction finishes the job.
    function automatic logic [11:0] mod_q(input logic signed [15:0] x);
        logic [16:0] y;
        logic [16:0] qm;
        logic [16:0] r;
        logic [29:0] prod;
        logic [5:0]  qh;
        y    = {x[15], x} + 17'd33290;
        prod = {13'd0, y} * 30'd5039;
        qh   = 6'(prod >> 24);
        qm   = {11'd0, qh} * 17'd3329;
        r    = y - qm;
        if (r >= 17'd3329) begin
            r = r - 17'd3329;
        end
        return 12'(r);
    endfunction

    logic [D-1:0]     w_coef  [NCOEF];
    logic [NBITS-1:0] w_bits;
    logic [7:0]       w_bytes [NBYTE];
    logic             w_unused_fbits;

    logic [7:0]       r_b     [NBYTE];
    logic             r_done;

    // Reduce every coefficient to its D-bit representative.
    always_comb begin
        for (int unsigned i = 0; i < NCOEF; i++) begin
            w_coef[i] = F[i][D-1:0];
`ifdef BYTE_ENCODE_MODQ_EN
            if (D == 12) begin
                w_coef[i] = D'(mod_q(F[i]));
            end
`endif
        end
    end

    // Fold all coefficient bits together so bits a build does not pack are
    // still consumed; the result drives nothing.
    always_comb begin
        w_unused_fbits = 1'b0;
        for (int unsigned i = 0; i < NCOEF; i++) begin
            w_unused_fbits = w_unused_fbits ^ (^F[i]);
        end
    end

    // Concatenate coefficients LSB-first into one contiguous bit string.
    always_comb begin
        w_bits = '0;
        for (int unsigned i = 0; i < NCOEF; i++) begin
            w_bits[i*D +: D] = w_coef[i];
        end
    end

    // Slice the bit string into bytes; byte k holds bits 8k..8k+7.
    always_comb begin
        for (int unsigned k = 0; k < NBYTE; k++) begin
            w_bytes[k] = w_bits[8*k +: 8];
        end
    end

    // Capture the encoding on start; hold otherwise; done pulses with start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NBYTE; k++) begin
                r_b[k] <= '0;
            end
            r_done <= 1'b0;
        end else begin
            r_done <= start;
            if (start) begin
                for (int unsigned k = 0; k < NBYTE; k++) begin
                    r_b[k] <= w_bytes[k];
                end
            end
        end
    end

    // Drive the output ports from the registered state.
    always_comb begin
        for (int unsigned k = 0; k < NBYTE; k++) begin
            B[k] = r_b[k];
        end
        done = r_done;
    end

endmodule

// File: tb/tb_byte_encode.sv
// Scoreboard bench for byte_encode: six instances (D = 12,11,10,5,4,1)
// share clock, reset and start. The driver pushes the reference encoding
// for every instance whenever it issues a start; a monitor pops on each
// result and otherwise checks that B holds its last value.
`timescale 1ns/1ps

module tb_byte_encode;

    localparam int NI = 6;
    localparam int DL [NI] = '{12, 11, 10, 5, 4, 1};

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [15:0] f12 [255:0];
    logic signed [15:0] fs  [255:0];

    logic [3071:0] pk   [NI];
    logic          dn   [NI];
    logic [3071:0] q    [NI][$];
    logic [3071:0] last [NI];

    int err = 0;
    int chk = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DD = DL[g];
        logic signed [15:0] fin [255:0];
        logic [7:0]         b   [32*DD-1:0];
        logic               d;
        logic [3071:0]      w_pk;

        always_comb begin
            if (DD == 12) fin = f12;
            else          fin = fs;
        end

        byte_encode #(.D(DD), .BYTE_LEN(32)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .F     (fin),
            .B     (b),
            .done  (d)
        );

        always_comb begin
            w_pk = '0;
            for (int k = 0; k < 32*DD; k++) w_pk[8*k +: 8] = b[k];
        end
        assign pk[g] = w_pk;
        assign dn[g] = d;
    end

    // Reference: reduce each coefficient arithmetically, lay the bits out as
    // bit[i*d+j] = a_i[j]; byte k of the result is bits 8k..8k+7.
    function automatic logic [3071:0] model(input int d, input logic signed [15:0] f [255:0]);
        logic [3071:0] v;
        int pos;
        int x;
        int a;
        v = '0;
        pos = 0;
        for (int i = 0; i < 256; i++) begin
            x = int'(f[i]);
            if (d == 12) begin
`ifdef BYTE_ENCODE_MODQ_EN
                a = ((x % 3329) + 3329) % 3329;
`else
                a = x & 4095;
`endif
            end else begin
                a = x & ((1 << d) - 1);
            end
            for (int j = 0; j < d; j++) begin
                v[pos] = 1'((a >> j) & 1);
                pos++;
            end
        end
        return v;
    endfunction

    task automatic push_all();
        for (int g = 0; g < NI; g++) begin
            if (DL[g] == 12) q[g].push_back(model(12, f12));
            else             q[g].push_back(model(DL[g], fs));
        end
    endtask

    // Drive start for one cycle (inputs change on the falling edge).
    task automatic step(input logic s);
        start = s;
        if (s && !rst) push_all();
        @(negedge clk);
    endtask

    task automatic clear_f();
        for (int i = 0; i < 256; i++) begin
            f12[i] = '0;
            fs[i]  = '0;
        end
    endtask

    task automatic rand_f();
        for (int i = 0; i < 256; i++) begin
            fs[i] = 16'($urandom);
`ifdef BYTE_ENCODE_MODQ_EN
            f12[i] = 16'($urandom);
`else
            f12[i] = 16'($urandom_range(0, 3328));
`endif
        end
    endtask

    // Monitor: 1 time unit after each clock edge or reset assertion.
    always @(posedge clk or posedge rst) begin
        #1;
        for (int g = 0; g < NI; g++) begin
            logic want_done;
            int   bad;
            if (rst) begin
                q[g].delete();
                last[g] = '0;
                want_done = 1'b0;
            end else begin
                want_done = (q[g].size() != 0);
                if (want_done) last[g] = q[g].pop_front();
            end
            chk++;
            if (dn[g] !== want_done) begin
                err++;
                $display("FAIL done D=%0d t=%0t got=%0b want=%0b", DL[g], $time, dn[g], want_done);
            end
            chk++;
            if (pk[g] !== last[g]) begin
                err++;
                bad = 0;
                for (int k = 383; k >= 0; k--)
                    if (pk[g][8*k +: 8] !== last[g][8*k +: 8]) bad = k;
                $display("FAIL bytes D=%0d t=%0t byte %0d got=%02h want=%02h",
                         DL[g], $time, bad, pk[g][8*bad +: 8], last[g][8*bad +: 8]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_f();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vector for D=12; alternating bits for the D<12 group.
        f12[0] = 106;  f12[1] = 1613; f12[2] = 2786; f12[3] = 3016;
        f12[254] = 1197; f12[255] = 1817;
        for (int i = 0; i < 256; i++) fs[i] = 16'(i & 1);
        step(1'b1);
        step(1'b0);

        // Boundary of the D=10 field: 1023 fits, 1024 wraps to zero.
        clear_f();
        fs[0] = 1023; fs[1] = 1024;
`ifdef BYTE_ENCODE_MODQ_EN
        f12[0] = 3329; f12[1] = -16'sd1;
        f12[2] = -16'sd32768; f12[3] = 16'sd32767;
`endif
        step(1'b1);
        step(1'b0);

        // All-zero and all-maximum coefficients.
        clear_f();
        step(1'b1);
        for (int i = 0; i < 256; i++) begin
            fs[i]  = -16'sd1;
            f12[i] = 3328;
        end
        step(1'b1);
        step(1'b0);

        // Single pulse, then F changes while idle, then start held 3 cycles.
        rand_f();
        step(1'b1);
        rand_f();
        step(1'b0);
        rand_f();
        step(1'b0);
        for (int n = 0; n < 3; n++) begin
            rand_f();
            step(1'b1);
        end
        rand_f();
        step(1'b0);

        // Asynchronous reset shortly after a start edge.
        rand_f();
        start = 1'b1;
        push_all();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);

        // Reset asserted across a start edge: nothing is captured.
        rand_f();
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        step(1'b0);

        // Reset mid-cycle after a valid result has been sitting in B.
        rand_f();
        step(1'b1);
        step(1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);

        // Random traffic with back-to-back and idle cycles.
        for (int n = 0; n < 40; n++) begin
            rand_f();
            step(1'($urandom_range(0, 1)));
        end
        step(1'b0);
        step(1'b0);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
